// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan scheduler for a multiplexed 7-segment display.
// The display data is held in shadow registers that load only at frame wrap.
// Each digit slot starts with a blanking gap, and per-digit blink is supported.
// Ports:
//   CLK_12       board clock, rising edge
//   nCR          asynchronous active-low reset
//   digits_in    4-bit code per digit, digit k = [4k+3:4k]
//   dp_in        decimal point request per digit
//   blink_mask   1 = digit participates in blink
//   blink_phase  1 = blinking digits dark (sampled every cycle)
//   sel          current digit index
//   dig_en       digit driver enable (inverted when ACT_LOW)
//   seg          {dp,g,f,e,d,c,b,a}, 1 = lit (inverted when ACT_LOW)
//   frame_start  1-cycle pulse on the first cycle of each frame
module seg_scan_ctrl #(
    parameter int unsigned DIGITS  = 6,
    parameter int unsigned DWELL   = 128,
    parameter int unsigned BLANK   = 8,
    parameter int unsigned ACT_LOW = 0
) (
    input  logic                  CLK_12,
    input  logic                  nCR,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blink_phase,
    output logic [2:0]            sel,
    output logic                  dig_en,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int unsigned CW  = $clog2(DWELL);
    localparam logic        INV = (ACT_LOW != 0);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          sel_d;
    logic                slot_end, wrap;
    logic [4*DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blk_q, sh_blk_d;
    logic [3:0]          cur_code;
    logic                cur_dp, cur_blk;
    logic [7:0]          seg_d;
    logic                dig_en_d;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] r;
        case (code)
            4'h0:    r = 7'h3F;
            4'h1:    r = 7'h06;
            4'h2:    r = 7'h5B;
            4'h3:    r = 7'h4F;
            4'h4:    r = 7'h66;
            4'h5:    r = 7'h6D;
            4'h6:    r = 7'h7D;
            4'h7:    r = 7'h07;
            4'h8:    r = 7'h7F;
            4'h9:    r = 7'h6F;
            4'hA:    r = 7'h40;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // Slot counter, digit index and frame-boundary shadow load
    always_comb begin
        slot_end = (cnt_q == CW'(DWELL - 1));
        wrap     = slot_end && (sel == 3'(DIGITS - 1));
        cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
        sel_d    = wrap ? 3'd0 : (slot_end ? sel + 3'd1 : sel);
        sh_dig_d = wrap ? digits_in  : sh_dig_q;
        sh_dp_d  = wrap ? dp_in      : sh_dp_q;
        sh_blk_d = wrap ? blink_mask : sh_blk_q;
    end

    // State register
    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: blanking gap at slot start, then show until slot end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d == CW'(BLANK)) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end)            state_d = ST_BLANK;
            default:                           state_d = ST_BLANK;
        endcase
    end

    // Output values for the next cycle, from next state/index/shadow
    always_comb begin
        cur_code = 4'hF;
        cur_dp   = 1'b0;
        cur_blk  = 1'b0;
        seg_d    = 8'h00;
        dig_en_d = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (sel_d == 3'(k)) begin
                cur_code = sh_dig_d[4*k +: 4];
                cur_dp   = sh_dp_d[k];
                cur_blk  = sh_blk_d[k];
            end
        end
        if (state_d == ST_SHOW) begin
            dig_en_d = 1'b1;
            if (!(cur_blk && blink_phase)) begin
                seg_d = {cur_dp, decode(cur_code)};
            end
        end
    end

    // Datapath and output registers; polarity applied before the flops
    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            cnt_q       <= '0;
            sel         <= 3'd0;
            sh_dig_q    <= {DIGITS{4'hF}};
            sh_dp_q     <= '0;
            sh_blk_q    <= '0;
            seg         <= {8{INV}};
            dig_en      <= INV;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel         <= sel_d;
            sh_dig_q    <= sh_dig_d;
            sh_dp_q     <= sh_dp_d;
            sh_blk_q    <= sh_blk_d;
            seg         <= seg_d ^ {8{INV}};
            dig_en      <= dig_en_d ^ INV;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: DIGITS=6, DWELL=4, BLANK=1, with an active-high
// and an active-low instance driven in parallel.
module tb_seg_scan_ctrl;

    logic        CLK_12 = 1'b0;
    logic        nCR = 1'b1;
    logic [23:0] digits_in = 24'h888888;
    logic [5:0]  dp_in = 6'h3F;
    logic [5:0]  blink_mask = 6'h00;
    logic        blink_phase = 1'b0;

    logic [2:0]  sel, sel_l;
    logic        dig_en, dig_en_l;
    logic [7:0]  seg, seg_l;
    logic        frame_start, fs_l;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] digits;
        logic [5:0]  dp;
        logic [5:0]  mask;
        logic        ph;
        logic [47:0] exp;   // expected seg per slot, slot0 in low byte
    } vec_t;

    vec_t vecs [6];

    seg_scan_ctrl #(.DIGITS(6), .DWELL(4), .BLANK(1), .ACT_LOW(0)) dut_h (
        .CLK_12(CLK_12), .nCR(nCR), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .blink_phase(blink_phase),
        .sel(sel), .dig_en(dig_en), .seg(seg), .frame_start(frame_start)
    );

    seg_scan_ctrl #(.DIGITS(6), .DWELL(4), .BLANK(1), .ACT_LOW(1)) dut_l (
        .CLK_12(CLK_12), .nCR(nCR), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .blink_phase(blink_phase),
        .sel(sel_l), .dig_en(dig_en_l), .seg(seg_l), .frame_start(fs_l)
    );

    always #5 CLK_12 = ~CLK_12;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input string nm, input logic [2:0] s, input logic en,
                               input logic [7:0] sg, input logic fs);
        logic [7:0] nsg;
        logic       nen;
        nsg = ~sg;
        nen = ~en;
        chk({nm, " sel"},      32'(sel),         32'(s));
        chk({nm, " dig_en"},   32'(dig_en),      32'(en));
        chk({nm, " seg"},      32'(seg),         32'(sg));
        chk({nm, " fs"},       32'(frame_start), 32'(fs));
        chk({nm, " sel_l"},    32'(sel_l),       32'(s));
        chk({nm, " dig_en_l"}, 32'(dig_en_l),    32'(nen));
        chk({nm, " seg_l"},    32'(seg_l),       32'(nsg));
        chk({nm, " fs_l"},     32'(fs_l),        32'(fs));
    endtask

    // Checks a whole frame starting at the current (frame_start) negedge
    task automatic check_frame(input string nm, input logic [47:0] e,
                               input int tear_cyc, input logic [23:0] tear_val);
        int         slot, ph;
        logic       en;
        logic [7:0] sg;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge CLK_12);
            slot = c / 4;
            ph   = c % 4;
            en   = (ph != 0);
            sg   = en ? e[8*slot +: 8] : 8'h00;
            check_cycle(nm, 3'(slot), en, sg, c == 0);
            if (c == tear_cyc) digits_in = tear_val;
        end
    endtask

    task automatic wait_fs(input string nm);
        int n;
        n = 0;
        @(negedge CLK_12);
        while (!frame_start && n < 60) begin
            @(negedge CLK_12);
            n++;
        end
        chk({nm, " frame_start wait"}, 32'(frame_start), 32'd1);
    endtask

    // First frame after reset release: blank digits, wrap after 24 cycles
    task automatic check_boot(input string nm);
        for (int c = 1; c <= 24; c++) begin
            @(negedge CLK_12);
            check_cycle(nm, 3'((c % 24) / 4), (c % 4) != 0, 8'h00, c == 24);
        end
    endtask

    initial begin
        vecs[0] = '{24'h98A10F, 6'b000100, 6'b000000, 1'b0, 48'h6F_7F_40_86_3F_00};
        vecs[1] = '{24'h765432, 6'b000000, 6'b000000, 1'b0, 48'h07_7D_6D_66_4F_5B};
        vecs[2] = '{24'h543210, 6'b000000, 6'b000011, 1'b1, 48'h6D_66_4F_5B_00_00};
        vecs[3] = '{24'h543210, 6'b000000, 6'b000011, 1'b0, 48'h6D_66_4F_5B_06_3F};
        vecs[4] = '{24'hBCDEF8, 6'b111110, 6'b000000, 1'b0, 48'h80_80_80_80_80_7F};
        vecs[5] = '{24'h000008, 6'b000001, 6'b000001, 1'b1, 48'h3F_3F_3F_3F_3F_00};

        #2 nCR = 1'b0;
        #1 check_cycle("reset", 3'd0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge CLK_12);
        nCR = 1'b1;
        check_boot("boot1");
        check_frame("first load", 48'hFF_FF_FF_FF_FF_FF, -1, 24'h0);

        for (int i = 0; i < 6; i++) begin
            digits_in   = vecs[i].digits;
            dp_in       = vecs[i].dp;
            blink_mask  = vecs[i].mask;
            blink_phase = vecs[i].ph;
            wait_fs($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp, -1, 24'h0);
        end

        // Data change mid-frame must wait for the next frame boundary
        digits_in   = vecs[0].digits;
        dp_in       = vecs[0].dp;
        blink_mask  = 6'b000000;
        blink_phase = 1'b0;
        wait_fs("tear");
        check_frame("tear", vecs[0].exp, 13, 24'h765432);
        @(negedge CLK_12);
        check_frame("post tear", 48'h07_7D_6D_E6_4F_5B, -1, 24'h0);

        // blink_phase acts within the frame
        digits_in  = 24'h543210;
        dp_in      = 6'b000000;
        blink_mask = 6'b000011;
        wait_fs("blink mid");
        repeat (5) @(negedge CLK_12);
        check_cycle("blink pre", 3'd1, 1'b1, 8'h06, 1'b0);
        blink_phase = 1'b1;
        @(negedge CLK_12);
        check_cycle("blink on", 3'd1, 1'b1, 8'h00, 1'b0);
        blink_phase = 1'b0;
        @(negedge CLK_12);
        check_cycle("blink off", 3'd1, 1'b1, 8'h06, 1'b0);

        // Asynchronous reset mid-scan, then fresh boot
        #2 nCR = 1'b0;
        #1 check_cycle("async reset", 3'd0, 1'b0, 8'h00, 1'b0);
        digits_in  = 24'h123456;
        dp_in      = 6'b000000;
        blink_mask = 6'b000000;
        @(negedge CLK_12);
        nCR = 1'b1;
        check_boot("boot2");
        check_frame("reload", 48'h06_5B_4F_66_6D_7D, -1, 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
